// File: rtl/ok_btpipe_out_buffer.sv
// First-word-fall-through FIFO that splits wide user words into 16-bit host
// words for an okBTPipeOut endpoint, with block-level ready handshaking.
module ok_btpipe_out_buffer #(
    parameter int unsigned RATIO     = 2,
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned BLOCK_LEN = 256
) (
    input  logic                  ti_clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [16*RATIO-1:0]   wr_data,
    output logic                  full,
    input  logic                  ep_read,
    input  logic                  ep_blockstrobe,
    output logic [15:0]           ep_datain,
    output logic                  ep_ready,
    output logic [ADDR_W:0]       level,
    output logic                  overflow,
    output logic                  underflow,
    output logic [15:0]           blocks_done
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    // Wide enough for RATIO*DEPTH host words (RATIO <= 4).
    localparam int unsigned CW    = ADDR_W + 3;
    localparam int unsigned SW    = 2;

    localparam logic [CW-1:0]     RATIO_C = CW'(RATIO);
    localparam logic [CW-1:0]     BLOCK_C = CW'(BLOCK_LEN);
    localparam logic [SW-1:0]     SEL_MAX = SW'(RATIO - 1);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {StIdle, StXfer} state_e;

    logic [16*RATIO-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [SW-1:0]       sel_q, sel_d;
    logic [ADDR_W:0]     level_q, level_d;
    logic [CW-1:0]       rem_q, rem_d;
    logic [15:0]         blocks_q, blocks_d;
    state_e              state_q, state_d;
    logic                ovf_q, unf_q, ready_q, ready_d;
    logic                do_write, rd_ok, pop, nonempty;
    logic [CW-1:0]       avail_d;
    logic [16*RATIO-1:0] head;

    assign full        = (level_q == DEPTH_C);
    assign nonempty    = (level_q != '0);
    assign do_write    = wr_en && !full;
    assign rd_ok       = ep_read && nonempty;
    assign pop         = rd_ok && (sel_q == SEL_MAX);
    assign head        = mem[rd_ptr_q];
    assign level       = level_q;
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign blocks_done = blocks_q;
    assign ep_ready    = ready_q;

    // Present the selected 16-bit slice of the head word; zero when empty.
    always_comb begin
        ep_datain = '0;
        if (nonempty) begin
            for (int i = 0; i < int'(RATIO); i++) begin
                if (sel_q == SW'(i)) ep_datain = head[i*16 +: 16];
            end
        end
    end

    // Next-state for slice select, occupancy, block FSM and ready flag.
    always_comb begin
        sel_d    = sel_q;
        level_d  = level_q;
        state_d  = state_q;
        rem_d    = rem_q;
        blocks_d = blocks_q;
        if (rd_ok) sel_d = pop ? '0 : sel_q + 1'b1;
        level_d = level_q + (ADDR_W + 1)'(do_write) - (ADDR_W + 1)'(pop);
        case (state_q)
            StIdle: begin
                if (ep_blockstrobe) begin
                    state_d = StXfer;
                    rem_d   = BLOCK_C;
                end
            end
            StXfer: begin
                if (ep_read) begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == CW'(1)) begin
                        state_d  = StIdle;
                        blocks_d = blocks_q + 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        avail_d = CW'(level_d) * RATIO_C - CW'(sel_d);
        ready_d = (state_d == StIdle) && (avail_d >= BLOCK_C);
    end

    // State registers with synchronous reset.
    always_ff @(posedge ti_clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sel_q    <= '0;
            level_q  <= '0;
            rem_q    <= '0;
            blocks_q <= '0;
            state_q  <= StIdle;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            if (do_write) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && full)     ovf_q <= 1'b1;
            if (ep_read && !nonempty) unf_q <= 1'b1;
            sel_q    <= sel_d;
            level_q  <= level_d;
            rem_q    <= rem_d;
            blocks_q <= blocks_d;
            state_q  <= state_d;
            ready_q  <= ready_d;
        end
    end

    // FIFO storage; contents are not cleared by reset.
    always_ff @(posedge ti_clk) begin
        if (!reset && do_write) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_ok_btpipe_out_buffer.sv
// Randomised and directed checks of ok_btpipe_out_buffer against a queue model.
module tb_ok_btpipe_out_buffer;

    localparam int R  = 2;
    localparam int AW = 4;
    localparam int BL = 8;
    localparam int DEPTH = 1 << AW;

    logic            ti_clk = 1'b0;
    logic            reset, wr_en, ep_read, ep_blockstrobe;
    logic [16*R-1:0] wr_data;
    logic            full, ep_ready, overflow, underflow;
    logic [15:0]     ep_datain, blocks_done;
    logic [AW:0]     level;

    ok_btpipe_out_buffer #(.RATIO(R), .ADDR_W(AW), .BLOCK_LEN(BL)) dut (
        .ti_clk         (ti_clk),
        .reset          (reset),
        .wr_en          (wr_en),
        .wr_data        (wr_data),
        .full           (full),
        .ep_read        (ep_read),
        .ep_blockstrobe (ep_blockstrobe),
        .ep_datain      (ep_datain),
        .ep_ready       (ep_ready),
        .level          (level),
        .overflow       (overflow),
        .underflow      (underflow),
        .blocks_done    (blocks_done)
    );

    always #5 ti_clk = ~ti_clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stored user words, host-word cursor and block bookkeeping.
    logic [16*R-1:0] q[$];
    int  m_sel, m_rem, m_blk;
    bit  m_ovf, m_unf, m_xfer, m_rdy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] model_datain();
        logic [16*R-1:0] h;
        if (q.size() == 0) return 16'h0;
        h = q[0];
        return 16'(h >> (16 * m_sel));
    endfunction

    function automatic int model_avail();
        return q.size() * R - m_sel;
    endfunction

    task automatic model_reset();
        q.delete();
        m_sel = 0; m_rem = 0; m_blk = 0;
        m_ovf = 0; m_unf = 0; m_xfer = 0; m_rdy = 0;
    endtask

    task automatic model_step(input bit rst, input bit wr, input logic [16*R-1:0] d,
                              input bit rd, input bit bs);
        bit was_full;
        if (rst) begin
            model_reset();
            return;
        end
        was_full = (q.size() == DEPTH);
        if (rd) begin
            if (q.size() > 0) begin
                m_sel++;
                if (m_sel == R) begin
                    void'(q.pop_front());
                    m_sel = 0;
                end
            end else begin
                m_unf = 1;
            end
        end
        if (wr) begin
            if (was_full) m_ovf = 1;
            else q.push_back(d);
        end
        if (m_xfer) begin
            if (rd) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_xfer = 0;
                    m_blk  = (m_blk + 1) % 65536;
                end
            end
        end else if (bs) begin
            m_xfer = 1;
            m_rem  = BL;
        end
        m_rdy = !m_xfer && (model_avail() >= BL);
    endtask

    task automatic check_outputs();
        check_eq("level", 32'(level), 32'(q.size()));
        check_eq("full", 32'(full), 32'(q.size() == DEPTH));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        check_eq("underflow", 32'(underflow), 32'(m_unf));
        check_eq("blocks_done", 32'(blocks_done), 32'(m_blk));
        check_eq("ep_ready", 32'(ep_ready), 32'(m_rdy));
    endtask

    // One clock: drive, check the fall-through output, clock, check registered outputs.
    task automatic cycle(input bit rst, input bit wr, input logic [16*R-1:0] d,
                         input bit rd, input bit bs);
        reset = rst; wr_en = wr; wr_data = d; ep_read = rd; ep_blockstrobe = bs;
        #1;
        check_eq("ep_datain", 32'(ep_datain), 32'(model_datain()));
        @(posedge ti_clk);
        model_step(rst, wr, d, rd, bs);
        #1;
        check_outputs();
    endtask

    task automatic idle_cycle();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [16*R-1:0] first_word;
        reset = 1'b1; wr_en = 1'b0; wr_data = '0; ep_read = 1'b0; ep_blockstrobe = 1'b0;
        @(posedge ti_clk);
        @(posedge ti_clk);
        #1;
        model_reset();
        check_outputs();
        check_eq("reset_datain", 32'(ep_datain), 32'h0);

        // Fill one block, then stream it out.
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, {16'(16'h2222 * (i + 1)), 16'(16'h2222 * i + 16'h1111)}, 1'b0, 1'b0);
            if (i == 2) check_eq("ready_before_4th", 32'(ep_ready), 32'h0);
        end
        check_eq("ready_after_4th", 32'(ep_ready), 32'h1);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        check_eq("ready_in_xfer", 32'(ep_ready), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            #1;
            check_eq("block_word", 32'(ep_datain), 32'(16'h1111 * k));
            cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
        check_eq("blocks_done_1", 32'(blocks_done), 32'h1);
        check_eq("level_empty", 32'(level), 32'h0);
        check_eq("ready_done", 32'(ep_ready), 32'h0);

        // Fill to full, then overflow.
        for (int i = 0; i < DEPTH; i++) begin
            logic [16*R-1:0] w;
            w = 32'($urandom);
            if (i == 0) first_word = w;
            cycle(1'b0, 1'b1, w, 1'b0, 1'b0);
        end
        check_eq("full_16", 32'(full), 32'h1);
        check_eq("level_16", 32'(level), 32'(DEPTH));
        cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check_eq("overflow_17th", 32'(overflow), 32'h1);
        check_eq("level_17th", 32'(level), 32'(DEPTH));
        check_eq("head_kept", 32'(ep_datain), 32'(first_word[15:0]));

        // Write on full coinciding with the popping (second-slice) read.
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 32'h1234_5678, 1'b1, 1'b0);
        check_eq("full_wr_pop_level", 32'(level), 32'(DEPTH - 1));
        check_eq("full_wr_pop_ovf", 32'(overflow), 32'h1);

        // Read from an empty FIFO.
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check_eq("underflow_set", 32'(underflow), 32'h1);
        check_eq("underflow_level", 32'(level), 32'h0);
        #1;
        check_eq("underflow_datain", 32'(ep_datain), 32'h0);

        // Partial block, then reset in the middle of a transfer.
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 32'($urandom), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
        check_eq("partial_level", 32'(level), 32'h4);
        check_eq("partial_avail", 32'(model_avail()), 32'h7);
        cycle(1'b1, 1'b1, 32'h5555_5555, 1'b1, 1'b1);
        check_eq("midxfer_reset_level", 32'(level), 32'h0);
        check_eq("midxfer_reset_ready", 32'(ep_ready), 32'h0);
        check_eq("midxfer_reset_blocks", 32'(blocks_done), 32'h0);
        // Must be back in IDLE: a fresh block becomes ready after eight words.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 32'($urandom), 1'b0, 1'b0);
        check_eq("idle_after_reset", 32'(ep_ready), 32'h1);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++) begin
            bit rst, wr, rd, bs;
            rst = ($urandom_range(0, 299) == 0);
            wr  = ($urandom_range(0, 99) < 45);
            rd  = ($urandom_range(0, 99) < 50);
            bs  = ($urandom_range(0, 7) == 0);
            cycle(rst, wr, 32'($urandom), rd, bs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
